im_access_arbiter: RTL
======================

Name: im_access_arbiter

Overview:
- Shares the single word port of the instruction memory between two requesters: the IF-stage fetch port (read-only) and the program loader port (write bursts for boot and self-modifying code).
- Sits between the IF stage / loader and the IM array. The IM array is treated as synchronous: write on the clock edge, read data valid the cycle after the read.
- Enforces one access per cycle, locks the port for loader bursts, and bounds loader starvation.

Parameters:
- IDX_W, 10, word-index width; IM depth is 2^IDX_W words, default 1024.
- STARVE_MAX, 4, consecutive refused loader cycles after which the loader wins over fetch; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch accepted this cycle (combinational).
- f_rvalid  out  1  fetch data valid (registered, one cycle after accept).
- f_rdata  out  32  fetch instruction word; equals mem_rdata when f_rvalid=1, else 0.
- l_req  in  1  loader write request.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write word.
- l_last  in  1  marks the final word of a burst.
- l_gnt  out  1  loader word accepted this cycle (combinational).
- mem_en  out  1  IM access enable.
- mem_we  out  1  IM write enable.
- mem_idx  out  IDX_W  IM word index.
- mem_wdata  out  32  IM write data.
- mem_rdata  in  32  IM read data; valid the cycle after a read.
- busy  out  1  loader burst in progress (state LOAD).

Behaviour:
- State machine states: IDLE, LOAD. Reset (reset=0, asynchronous) forces state=IDLE, f_rvalid=0, starve counter=0. Combinational outputs are 0 while reset=0.
- Accept rules: a request is accepted when req&gnt in the same cycle. At most one of f_gnt / l_gnt is 1 per cycle. A requester must hold req and its address/data stable until gnt.
- IDLE arbitration:
  - Only one requester active: it wins.
  - Both active: fetch wins unless starve counter == STARVE_MAX, in which case the loader wins.
- IDLE to LOAD: on a loader accept with l_last=0. A loader accept with l_last=1 is a single-word burst and the state stays IDLE.
- LOAD:
  - l_gnt = l_req; f_gnt = 0 regardless of f_req.
  - On an accept with l_last=1, go to IDLE.
  - If l_req drops mid-burst, stay in LOAD. The port remains locked and no access is issued.
- Starve counter: 4-bit. Increments (saturating at STARVE_MAX) each cycle l_req=1 and l_gnt=0. Clears on any loader accept.
- Memory drive:
  - Winner's address drives mem_idx = addr[IDX_W+1:2]. Bits above IDX_W+1 are ignored, so addresses wrap modulo the IM size.
  - mem_en = f_gnt|l_gnt; mem_we = l_gnt; mem_wdata = l_wdata when l_gnt, else 0.
- Fetch latency: f_rvalid rises exactly 1 cycle after f_gnt and lasts 1 cycle. Back-to-back fetch accepts give f_rvalid=1 on consecutive cycles.
- Write then read: a fetch of the same index accepted in any cycle after a loader write returns the new word.
- Reset during LOAD: return to IDLE. Pending f_rvalid is dropped and the burst is aborted; the loader must restart it.

Optional Feature:
- Macro: IM_ALIGN_CHK_EN.
- Defined:
  - A request with addr[1:0]!=0 is still granted but issues no memory access (mem_en=0).
  - Extra output f_err (1 bit, registered): for a misaligned fetch, f_rvalid=1 and f_err=1 the next cycle, with f_rdata=0.
  - A misaligned loader word is dropped silently, but l_last still ends the burst.
  - f_err resets to 0.
- Undefined: f_err port absent; addr[1:0] ignored, access proceeds to the truncated index.

Test Plan:
- Fetch only, f_addr=0x00003004, mem_rdata=0x8C080000 -> f_gnt=1, mem_idx=1 same cycle; f_rvalid=1, f_rdata=0x8C080000 next cycle.
- Loader burst of 3 words to 0x0,0x4,0x8 (l_last on the third), f_req held high -> l_gnt three cycles, busy=1 for the burst, f_gnt=0 until IDLE; the first fetch after the burst reads the written word 0.
- f_req and l_req both held, STARVE_MAX=4 -> fetch granted 4 cycles, loader granted on cycle 5, counter clears, fetch resumes.
- Loader drops l_req mid-burst for 3 cycles with f_req=1 -> busy stays 1, mem_en=0, f_gnt=0; burst completes when l_req returns.
- reset=0 asserted while in LOAD with f_rvalid pending -> immediately busy=0, f_rvalid=0; after release, a fetch is granted in the first cycle.
- IM_ALIGN_CHK_EN defined, f_addr=0x00000006 -> f_gnt=1, mem_en=0; next cycle f_rvalid=1, f_err=1, f_rdata=0.

Source files
------------

// File: rtl/im_access_arbiter.sv
// Instruction-memory port arbiter: IF fetch (read) vs program loader (write bursts).
// Optional misaligned-address checking is enabled by defining IM_ALIGN_CHK_EN.
module im_access_arbiter #(
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_req,
  input  logic [31:0]      f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [31:0]      f_rdata,
`ifdef IM_ALIGN_CHK_EN
  output logic             f_err,
`endif
  input  logic             l_req,
  input  logic [31:0]      l_addr,
  input  logic [31:0]      l_wdata,
  input  logic             l_last,
  output logic             l_gnt,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;
  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  logic [0:0] r_state;
  logic [3:0] r_starve;
  logic       r_f_rvalid;
  logic       r_f_err;
  logic       w_f_gnt;
  logic       w_l_gnt;
  logic       w_l_prio;
  logic       w_f_ok;
  logic       w_l_ok;
  logic       w_unused;

`ifdef IM_ALIGN_CHK_EN
  assign w_f_ok = (f_addr[1:0] == 2'b00);
  assign w_l_ok = (l_addr[1:0] == 2'b00);
`else
  assign w_f_ok = 1'b1;
  assign w_l_ok = 1'b1;
`endif

  // Address bits outside the word index are deliberately ignored (wrap modulo IM size).
  assign w_unused = ^{f_addr[31:IDX_W+2], f_addr[1:0], l_addr[31:IDX_W+2], l_addr[1:0]};

  assign w_l_prio = (r_starve == LP_STARVE_MAX);

  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          if (l_req && (!f_req || w_l_prio)) begin
            w_l_gnt = 1'b1;
          end else if (f_req) begin
            w_f_gnt = 1'b1;
          end
        end
        S_LOAD: w_l_gnt = l_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = (w_f_gnt & w_f_ok) | (w_l_gnt & w_l_ok);
    mem_we    = w_l_gnt & w_l_ok;
    mem_wdata = mem_we ? l_wdata : '0;
    if (w_l_gnt) begin
      mem_idx = l_addr[IDX_W+1:2];
    end else if (w_f_gnt) begin
      mem_idx = f_addr[IDX_W+1:2];
    end else begin
      mem_idx = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_l_gnt && !l_last) r_state <= S_LOAD;
        S_LOAD:  if (w_l_gnt && l_last)  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Counts refused loader cycles; any loader accept restores fetch priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (w_l_gnt) begin
      r_starve <= '0;
    end else if (l_req && (r_starve < LP_STARVE_MAX)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f_rvalid <= 1'b0;
      r_f_err    <= 1'b0;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_f_err    <= w_f_gnt & ~w_f_ok;
    end
  end

  assign f_gnt    = w_f_gnt;
  assign l_gnt    = w_l_gnt;
  assign f_rvalid = r_f_rvalid;
  assign f_rdata  = (r_f_rvalid && !r_f_err) ? mem_rdata : '0;
  assign busy     = (r_state == S_LOAD);
`ifdef IM_ALIGN_CHK_EN
  assign f_err    = r_f_err;
`endif

endmodule
